// File: rtl/mem_pkg.sv
// Shared definitions for the mem_responder slice.
//   DATA_WIDTH : width of a memory word (two byte lanes)
//   ADDR_WIDTH : width of the byte address; the word index is address[15:1]
//   state_t    : responder FSM encoding
package mem_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
//   read, write   : requests, held by the initiator until resp
//   byte_enable   : write lane mask (bit0 -> [7:0], bit1 -> [15:8])
//   address       : byte address
//   wdata         : write data
//   resp          : one-cycle completion pulse
//   rdata         : read data, held between completions
//   err           : sticky protocol-error flag
interface mem_responder_if;
  import mem_pkg::*;

  logic                  read;
  logic                  write;
  logic [1:0]            byte_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  resp;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output read, write, byte_enable, address, wdata,
    input  resp, rdata, err
  );

  modport slave (
    input  read, write, byte_enable, address, wdata,
    output resp, rdata, err
  );

endinterface

// File: rtl/mem_array.sv
// Word storage for mem_responder.
//   clk   : write clock
//   we    : commit wdata to the selected word on the rising edge
//   be    : byte-lane mask for the write
//   word  : word index, reduced modulo DEPTH internally
//   wdata : write data
//   rdata : combinational read of the selected word
// Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 32768
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [ADDR_WIDTH-2:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         idx;

  // Indices at or above DEPTH wrap around.
  assign idx = IW'(32'(word) % DEPTH);

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[idx][7:0]  <= wdata[7:0];
      if (be[1]) mem[idx][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset (memory contents survive it)
//   bus     : slave side of mem_responder_if
// A request sampled in IDLE is captured and answered DELAY cycles later
// with a one-cycle resp. Dropping the request while BUSY aborts it;
// read and write together in IDLE is ignored and sets the sticky err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DELAY = 3,
  parameter int unsigned DEPTH = 32768
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_responder_if.slave bus
);

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  op_write;
  logic [ADDR_WIDTH-2:0] word_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err;

  logic                  capture;
  logic                  load_rdata;
  logic                  err_set;
  logic                  req_held;
  logic [ADDR_WIDTH-2:0] mem_word;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = bus.address[0];

  assign req_held = op_write ? bus.write : bus.read;

  // In IDLE the live address feeds the array so a DELAY=1 read can load
  // rdata on the capture edge; afterwards the captured index is used.
  assign mem_word = (state == IDLE) ? bus.address[ADDR_WIDTH-1:1] : word_q;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    capture    = 1'b0;
    load_rdata = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.read ^ bus.write) begin
          capture = 1'b1;
          // With DELAY=1 there are no BUSY cycles to count.
          if (DELAY == 1) begin
            state_n    = RESP;
            load_rdata = bus.read;
          end else begin
            state_n = BUSY;
            cnt_n   = 4'd1;
          end
        end
      end
      BUSY: begin
        if (!req_held) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == 4'(DELAY - 1)) begin
          state_n    = RESP;
          cnt_n      = '0;
          load_rdata = !op_write;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign err_set = (state == IDLE) && bus.read && bus.write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        op_write <= bus.write;
        word_q   <= bus.address[ADDR_WIDTH-1:1];
        wdata_q  <= bus.wdata;
        be_q     <= bus.byte_enable;
      end
      if (load_rdata) rdata_q <= mem_rdata;
      if (err_set)    err     <= 1'b1;
    end
  end

  // Write commits on the edge that ends RESP; reset forces IDLE first.
  assign mem_we = (state == RESP) && op_write;

  mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be_q),
    .word  (mem_word),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.resp  = (state == RESP);
  assign bus.rdata = rdata_q;
  assign bus.err   = err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DELAY=3/DEPTH=256 instance and
// one DELAY=1 instance share the clock, reset and request drivers.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;
  logic        req_rd, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_be;
  logic        o_resp, o_err;
  logic [15:0] o_rdata;
  logic [15:0] rd;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  mem_responder_if if3 ();
  mem_responder_if if1 ();

  assign if3.read        = !sel && req_rd;
  assign if3.write       = !sel && req_wr;
  assign if3.byte_enable = req_be;
  assign if3.address     = req_addr;
  assign if3.wdata       = req_wdata;
  assign if1.read        = sel && req_rd;
  assign if1.write       = sel && req_wr;
  assign if1.byte_enable = req_be;
  assign if1.address     = req_addr;
  assign if1.wdata       = req_wdata;

  assign o_resp  = sel ? if1.resp  : if3.resp;
  assign o_rdata = sel ? if1.rdata : if3.rdata;
  assign o_err   = sel ? if1.err   : if3.err;

  mem_responder #(.DELAY(3), .DEPTH(256)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3)
  );

  mem_responder #(.DELAY(1), .DEPTH(32768)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request in the current cycle, wait (bounded) for resp, check
  // its latency, drop the request and check resp is a single pulse.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      input logic [1:0] be, input int exp_lat, input string tag,
                      output logic [15:0] rdo);
    int k;
    k = 0;
    req_wr = wr; req_rd = !wr; req_addr = addr; req_wdata = data; req_be = be;
    do begin
      tick();
      k++;
    end while (!o_resp && k < 20);
    check({tag, "_lat"}, k, exp_lat);
    rdo = o_rdata;
    req_rd = 1'b0; req_wr = 1'b0;
    tick();
    check({tag, "_pulse"}, {31'b0, o_resp}, 0);
  endtask

  initial begin
    sel = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = 2'b11;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_resp3",  {31'b0, if3.resp}, 0);
    check("rst_rdata3", {16'b0, if3.rdata}, 0);
    check("rst_err3",   {31'b0, if3.err}, 0);
    check("rst_resp1",  {31'b0, if1.resp}, 0);
    check("rst_rdata1", {16'b0, if1.rdata}, 0);
    reset_n = 1'b1;

    // Write then read back, latency 3 each.
    xfer(1'b1, 16'h0010, 16'hBEEF, 2'b11, 3, "wr_beef", rd);
    xfer(1'b0, 16'h0010, 16'h0000, 2'b00, 3, "rd_beef", rd);
    check("rd_beef_data", {16'b0, rd}, 32'hBEEF);
    check("rd_beef_hold", {16'b0, o_rdata}, 32'hBEEF);

    // Byte lanes.
    xfer(1'b1, 16'h0020, 16'h1234, 2'b11, 3, "wr_1234", rd);
    xfer(1'b1, 16'h0020, 16'hAB00, 2'b10, 3, "wr_hi", rd);
    xfer(1'b0, 16'h0020, 16'h0000, 2'b00, 3, "rd_ab34", rd);
    check("rd_ab34_data", {16'b0, rd}, 32'hAB34);
    xfer(1'b1, 16'h0020, 16'hFFCD, 2'b01, 3, "wr_lo", rd);
    xfer(1'b1, 16'h0020, 16'hFFFF, 2'b00, 3, "wr_none", rd);
    xfer(1'b0, 16'h0021, 16'h0000, 2'b00, 3, "rd_abcd", rd);
    check("rd_abcd_data", {16'b0, rd}, 32'hABCD);

    // Word index 0x109 wraps to 9 with DEPTH=256.
    xfer(1'b1, 16'h0212, 16'h7777, 2'b11, 3, "wr_wrap", rd);
    xfer(1'b0, 16'h0012, 16'h0000, 2'b00, 3, "rd_wrap", rd);
    check("rd_wrap_data", {16'b0, rd}, 32'h7777);

    // Address/data changes while BUSY are ignored.
    xfer(1'b1, 16'h0032, 16'h0101, 2'b11, 3, "wr_0101", rd);
    req_wr = 1'b1; req_rd = 1'b0; req_addr = 16'h0030; req_wdata = 16'hCAFE; req_be = 2'b11;
    tick();
    req_addr = 16'h0032; req_wdata = 16'h0000; req_be = 2'b00;
    n = 1;
    do begin
      tick();
      n++;
    end while (!o_resp && n < 20);
    check("wr_cafe_lat", n, 3);
    req_wr = 1'b0;
    tick();
    xfer(1'b0, 16'h0030, 16'h0000, 2'b00, 3, "rd_cafe", rd);
    check("rd_cafe_data", {16'b0, rd}, 32'hCAFE);
    xfer(1'b0, 16'h0032, 16'h0000, 2'b00, 3, "rd_0101", rd);
    check("rd_0101_data", {16'b0, rd}, 32'h0101);

    // Read dropped in cycle N+1: no resp, responder idle again.
    req_rd = 1'b1; req_addr = 16'h0010;
    tick();
    req_rd = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_resp) n++;
    end
    check("abort_rd_noresp", n, 0);
    // Write dropped in the last BUSY cycle must not commit.
    req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'h0000; req_be = 2'b11;
    tick();
    tick();
    req_wr = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_resp) n++;
    end
    check("abort_wr_noresp", n, 0);
    xfer(1'b0, 16'h0010, 16'h0000, 2'b00, 3, "rd_after_abort", rd);
    check("rd_after_abort_data", {16'b0, rd}, 32'hBEEF);

    // Read and write together: ignored, err sticks.
    req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'h0000; req_be = 2'b11;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_resp) n++;
    end
    check("both_noresp", n, 0);
    check("both_err", {31'b0, o_err}, 1);
    req_rd = 1'b0; req_wr = 1'b0;
    tick();
    xfer(1'b0, 16'h0010, 16'h0000, 2'b00, 3, "rd_after_both", rd);
    check("rd_after_both_data", {16'b0, rd}, 32'hBEEF);
    check("err_sticky", {31'b0, o_err}, 1);
    check("err_other_dut", {31'b0, if1.err}, 0);

    // Reset during BUSY discards the write.
    xfer(1'b1, 16'h0040, 16'h1111, 2'b11, 3, "wr_1111", rd);
    req_wr = 1'b1; req_addr = 16'h0040; req_wdata = 16'h5555; req_be = 2'b11;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_busy_resp",  {31'b0, o_resp}, 0);
    check("rst_busy_rdata", {16'b0, o_rdata}, 0);
    check("rst_busy_err",   {31'b0, o_err}, 0);
    req_wr = 1'b0;
    tick();
    reset_n = 1'b1;
    xfer(1'b0, 16'h0040, 16'h0000, 2'b00, 3, "rd_1111", rd);
    check("rd_1111_data", {16'b0, rd}, 32'h1111);

    // Reset during RESP discards the write as well.
    req_wr = 1'b1; req_addr = 16'h0040; req_wdata = 16'h2222; req_be = 2'b11;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_resp && n < 20);
    check("wr_2222_lat", n, 3);
    reset_n = 1'b0;
    #1;
    check("rst_resp_resp", {31'b0, o_resp}, 0);
    req_wr = 1'b0;
    tick();
    reset_n = 1'b1;
    xfer(1'b0, 16'h0040, 16'h0000, 2'b00, 3, "rd_still_1111", rd);
    check("rd_still_1111_data", {16'b0, rd}, 32'h1111);

    // DELAY=1 instance: back-to-back reads.
    sel = 1'b1;
    xfer(1'b1, 16'h0000, 16'hAAAA, 2'b11, 1, "d1_wr0", rd);
    xfer(1'b1, 16'h0002, 16'h5A5A, 2'b11, 1, "d1_wr2", rd);
    req_rd = 1'b1; req_addr = 16'h0000;
    tick();
    check("d1_n1_resp",  {31'b0, o_resp}, 1);
    check("d1_n1_rdata", {16'b0, o_rdata}, 32'hAAAA);
    req_addr = 16'h0002;
    tick();
    check("d1_n2_resp",  {31'b0, o_resp}, 0);
    tick();
    check("d1_n3_resp",  {31'b0, o_resp}, 1);
    check("d1_n3_rdata", {16'b0, o_rdata}, 32'h5A5A);
    req_rd = 1'b0;
    tick();
    check("d1_n4_resp",  {31'b0, o_resp}, 0);
    check("d1_n4_hold",  {16'b0, o_rdata}, 32'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
